// File: rtl/cdb_reservation_station.sv
// Four-entry ALU reservation station that snoops the CDB for pending operands and issues the oldest ready entry.
// Issue is combinational from registered state (dispatch/wakeup at edge N -> issuable in cycle N+1); issueReady low holds the selected entry.
module cdb_reservation_station #(
  parameter int WIDTH   = 31,
  parameter int ROB     = 2,
  parameter int CONTROL = 5,
  parameter int DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        flush,
  input  logic                        dispatchValid,
  output logic                        dispatchReady,
  input  logic [CONTROL:0]            dispatchControl,
  input  logic [ROB:0]                dispatchRob,
  input  logic                        src1Ready,
  input  logic                        src2Ready,
  input  logic [WIDTH:0]              src1Value,
  input  logic [WIDTH:0]              src2Value,
  input  logic [ROB:0]                src1Tag,
  input  logic [ROB:0]                src2Tag,
  input  logic                        cdbValid,
  input  logic [ROB:0]                cdbRob,
  input  logic [WIDTH:0]              cdbResult,
  output logic                        issueValid,
  input  logic                        issueReady,
  output logic [CONTROL:0]            issueControl,
  output logic [ROB:0]                issueRob,
  output logic [WIDTH:0]              issueOp1,
  output logic [WIDTH:0]              issueOp2,
  output logic [$clog2(DEPTH):0]      occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] rdy1;
  logic [DEPTH-1:0] rdy2;
  logic [CONTROL:0] ctrl [DEPTH];
  logic [ROB:0]     rob  [DEPTH];
  logic [ROB:0]     tag1 [DEPTH];
  logic [ROB:0]     tag2 [DEPTH];
  logic [WIDTH:0]   val1 [DEPTH];
  logic [WIDTH:0]   val2 [DEPTH];
  // older[i][j] set means entry i was dispatched before entry j; diagonal stays 0.
  logic [DEPTH-1:0] older [DEPTH];

  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] sel_oh;
  logic             alloc_found;
  logic             dispatch_fire;
  logic             issue_fire;
  logic             cdb_hit1;
  logic             cdb_hit2;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(valid[i]);
    end
  end

  assign dispatchReady = (occupancy < OCC_W'(DEPTH));
  assign dispatch_fire = dispatchValid && dispatchReady;
  assign issue_fire    = issueValid && issueReady;
  assign cdb_hit1      = !src1Ready && cdbValid && (cdbRob == src1Tag);
  assign cdb_hit2      = !src2Ready && cdbValid && (cdbRob == src2Tag);

  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  // Oldest ready entry: no other ready entry is older than it.
  always_comb begin
    ready_vec = valid & rdy1 & rdy2;
    sel_oh    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        blocked = blocked | (ready_vec[j] & older[j][i]);
      end
      sel_oh[i] = ready_vec[i] & ~blocked;
    end
  end

  always_comb begin
    issueValid   = |sel_oh;
    issueControl = '0;
    issueRob     = '0;
    issueOp1     = '0;
    issueOp2     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        issueControl = ctrl[i];
        issueRob     = rob[i];
        issueOp1     = val1[i];
        issueOp2     = val2[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      valid <= '0;
      rdy1  <= '0;
      rdy2  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl[i]  <= '0;
        rob[i]   <= '0;
        tag1[i]  <= '0;
        tag2[i]  <= '0;
        val1[i]  <= '0;
        val2[i]  <= '0;
        older[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (dispatch_fire && alloc_oh[i]) begin
          valid[i]  <= 1'b1;
          ctrl[i]   <= dispatchControl;
          rob[i]    <= dispatchRob;
          tag1[i]   <= src1Tag;
          tag2[i]   <= src2Tag;
          rdy1[i]   <= src1Ready | cdb_hit1;
          rdy2[i]   <= src2Ready | cdb_hit2;
          val1[i]   <= src1Ready ? src1Value : cdbResult;
          val2[i]   <= src2Ready ? src2Value : cdbResult;
          older[i]  <= '0;
        end else begin
          if (issue_fire && sel_oh[i]) begin
            valid[i] <= 1'b0;
          end
          if (valid[i] && !rdy1[i] && cdbValid && (cdbRob == tag1[i])) begin
            rdy1[i] <= 1'b1;
            val1[i] <= cdbResult;
          end
          if (valid[i] && !rdy2[i] && cdbValid && (cdbRob == tag2[i])) begin
            rdy2[i] <= 1'b1;
            val2[i] <= cdbResult;
          end
          if (dispatch_fire) begin
            older[i] <= older[i] | alloc_oh;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_reservation_station.sv
// Directed bench for cdb_reservation_station: each task drives one scenario and checks against hand-computed values.
module tb_cdb_reservation_station;

  logic        clk = 1'b0;
  logic        resetN;
  logic        flush;
  logic        dispatchValid;
  logic        dispatchReady;
  logic [5:0]  dispatchControl;
  logic [2:0]  dispatchRob;
  logic        src1Ready, src2Ready;
  logic [31:0] src1Value, src2Value;
  logic [2:0]  src1Tag, src2Tag;
  logic        cdbValid;
  logic [2:0]  cdbRob;
  logic [31:0] cdbResult;
  logic        issueValid;
  logic        issueReady;
  logic [5:0]  issueControl;
  logic [2:0]  issueRob;
  logic [31:0] issueOp1, issueOp2;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  cdb_reservation_station dut (
    .clk(clk), .resetN(resetN), .flush(flush),
    .dispatchValid(dispatchValid), .dispatchReady(dispatchReady),
    .dispatchControl(dispatchControl), .dispatchRob(dispatchRob),
    .src1Ready(src1Ready), .src2Ready(src2Ready),
    .src1Value(src1Value), .src2Value(src2Value),
    .src1Tag(src1Tag), .src2Tag(src2Tag),
    .cdbValid(cdbValid), .cdbRob(cdbRob), .cdbResult(cdbResult),
    .issueValid(issueValid), .issueReady(issueReady),
    .issueControl(issueControl), .issueRob(issueRob),
    .issueOp1(issueOp1), .issueOp2(issueOp2),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; dispatchValid = 0; dispatchControl = 0; dispatchRob = 0;
    src1Ready = 0; src2Ready = 0; src1Value = 0; src2Value = 0; src1Tag = 0; src2Tag = 0;
    cdbValid = 0; cdbRob = 0; cdbResult = 0; issueReady = 0;
  endtask

  task automatic drive_dispatch(input logic [5:0] c, input logic [2:0] r,
                                input logic r1, input logic [31:0] v1, input logic [2:0] t1,
                                input logic r2, input logic [31:0] v2, input logic [2:0] t2);
    dispatchValid = 1; dispatchControl = c; dispatchRob = r;
    src1Ready = r1; src1Value = v1; src1Tag = t1;
    src2Ready = r2; src2Value = v2; src2Tag = t2;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetN = 0;
    #12;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    checks++; if (dispatchReady !== 1'b1) begin errors++; $display("FAIL reset_dready: got %0b expected 1", dispatchReady); end
    checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL reset_ivalid: got %0b expected 0", issueValid); end
    checks++; if (issueOp1 !== 32'd0) begin errors++; $display("FAIL reset_op1: got %0d expected 0", issueOp1); end
    @(negedge clk);
    resetN = 1;
    step();
  endtask

  task automatic test_ready_dispatch();
    idle_inputs();
    issueReady = 1;
    drive_dispatch(6'h02, 3'd1, 1, 32'd60, 3'd0, 1, 32'd5, 3'd0);
    step();
    dispatchValid = 0;
    checks++; if (issueValid !== 1'b1) begin errors++; $display("FAIL rd_ivalid: got %0b expected 1", issueValid); end
    checks++; if (issueRob !== 3'd1) begin errors++; $display("FAIL rd_rob: got %0d expected 1", issueRob); end
    checks++; if (issueControl !== 6'h02) begin errors++; $display("FAIL rd_ctrl: got %0h expected 2", issueControl); end
    checks++; if (issueOp1 !== 32'd60) begin errors++; $display("FAIL rd_op1: got %0d expected 60", issueOp1); end
    checks++; if (issueOp2 !== 32'd5) begin errors++; $display("FAIL rd_op2: got %0d expected 5", issueOp2); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL rd_occ1: got %0d expected 1", occupancy); end
    step();
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rd_occ0: got %0d expected 0", occupancy); end
    checks++; if (issueValid !== 1'b0 || issueRob !== 3'd0) begin errors++; $display("FAIL rd_empty: got valid %0b rob %0d expected 0 0", issueValid, issueRob); end
  endtask

  task automatic test_wakeup();
    idle_inputs();
    drive_dispatch(6'h04, 3'd2, 0, 32'd0, 3'd1, 1, 32'd7, 3'd0);
    step();
    dispatchValid = 0;
    cdbValid = 1; cdbRob = 3'd5; cdbResult = 32'd123;
    checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL wk_pending: got %0b expected 0", issueValid); end
    step();
    cdbValid = 1; cdbRob = 3'd1; cdbResult = 32'd60;
    checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL wk_wrongtag: got %0b expected 0", issueValid); end
    #2;
    checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL wk_nobypass: got %0b expected 0", issueValid); end
    step();
    cdbValid = 0;
    checks++; if (issueValid !== 1'b1 || issueRob !== 3'd2) begin errors++; $display("FAIL wk_issue: got valid %0b rob %0d expected 1 2", issueValid, issueRob); end
    checks++; if (issueOp1 !== 32'd60 || issueOp2 !== 32'd7) begin errors++; $display("FAIL wk_ops: got %0d %0d expected 60 7", issueOp1, issueOp2); end
    issueReady = 1;
    step();
    issueReady = 0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL wk_drain: got %0d expected 0", occupancy); end
  endtask

  task automatic test_dispatch_capture();
    idle_inputs();
    drive_dispatch(6'h03, 3'd4, 1, 32'd11, 3'd0, 0, 32'd0, 3'd3);
    cdbValid = 1; cdbRob = 3'd3; cdbResult = 32'd99;
    step();
    idle_inputs();
    checks++; if (issueValid !== 1'b1 || issueRob !== 3'd4) begin errors++; $display("FAIL cap_issue: got valid %0b rob %0d expected 1 4", issueValid, issueRob); end
    checks++; if (issueOp1 !== 32'd11 || issueOp2 !== 32'd99) begin errors++; $display("FAIL cap_ops: got %0d %0d expected 11 99", issueOp1, issueOp2); end
    issueReady = 1;
    step();
    issueReady = 0;
  endtask

  task automatic test_dual_wakeup();
    idle_inputs();
    drive_dispatch(6'h07, 3'd5, 0, 32'd0, 3'd6, 0, 32'd0, 3'd6);
    step();
    idle_inputs();
    cdbValid = 1; cdbRob = 3'd6; cdbResult = 32'd42;
    step();
    idle_inputs();
    checks++; if (issueValid !== 1'b1 || issueOp1 !== 32'd42 || issueOp2 !== 32'd42) begin errors++; $display("FAIL dual_wake: got valid %0b ops %0d %0d expected 1 42 42", issueValid, issueOp1, issueOp2); end
    issueReady = 1;
    step();
    issueReady = 0;
  endtask

  task automatic test_full_and_order();
    logic [2:0] exp_rob [5];
    logic [2:0] exp_occ [5];
    exp_rob = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
    exp_occ = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      drive_dispatch(6'h01, 3'(k), 1, 32'(k * 10), 3'd0, 1, 32'(k), 3'd0);
      step();
    end
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ: got %0d expected 4", occupancy); end
    checks++; if (dispatchReady !== 1'b0) begin errors++; $display("FAIL full_dready: got %0b expected 0", dispatchReady); end
    drive_dispatch(6'h01, 3'd7, 1, 32'd70, 3'd0, 1, 32'd7, 3'd0);
    step();
    dispatchValid = 0;
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_ignore: got %0d expected 4", occupancy); end
    checks++; if (issueRob !== 3'd0 || issueOp1 !== 32'd0 || issueValid !== 1'b1) begin errors++; $display("FAIL full_hold: got rob %0d op1 %0d valid %0b expected 0 0 1", issueRob, issueOp1, issueValid); end
    issueReady = 1;
    step();
    issueReady = 0;
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL full_first: got %0d expected 3", occupancy); end
    // Entry 0 is reused by rob 5, which is younger than robs 1..3.
    drive_dispatch(6'h01, 3'd5, 1, 32'd50, 3'd0, 1, 32'd5, 3'd0);
    step();
    dispatchValid = 0;
    issueReady = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) drive_dispatch(6'h01, 3'd6, 1, 32'd60, 3'd0, 1, 32'd6, 3'd0);
      checks++; if (issueValid !== 1'b1 || issueRob !== exp_rob[k]) begin errors++; $display("FAIL order_%0d: got valid %0b rob %0d expected 1 %0d", k, issueValid, issueRob, exp_rob[k]); end
      step();
      dispatchValid = 0;
      checks++; if (occupancy !== exp_occ[k]) begin errors++; $display("FAIL order_occ_%0d: got %0d expected %0d", k, occupancy, exp_occ[k]); end
    end
    issueReady = 0;
  endtask

  task automatic test_flush();
    idle_inputs();
    for (int k = 1; k <= 3; k++) begin
      drive_dispatch(6'h05, 3'(k), 0, 32'd0, 3'd7, 1, 32'd1, 3'd0);
      step();
    end
    dispatchValid = 0;
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL fl_pre: got %0d expected 3", occupancy); end
    flush = 1;
    drive_dispatch(6'h05, 3'd4, 1, 32'd1, 3'd0, 1, 32'd1, 3'd0);
    cdbValid = 1; cdbRob = 3'd7; cdbResult = 32'd77;
    step();
    idle_inputs();
    checks++; if (occupancy !== 3'd0 || issueValid !== 1'b0) begin errors++; $display("FAIL fl_clear: got occ %0d valid %0b expected 0 0", occupancy, issueValid); end
    step();
    checks++; if (occupancy !== 3'd0 || issueValid !== 1'b0) begin errors++; $display("FAIL fl_stay: got occ %0d valid %0b expected 0 0", occupancy, issueValid); end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    drive_dispatch(6'h09, 3'd2, 1, 32'd8, 3'd0, 1, 32'd9, 3'd0);
    step();
    drive_dispatch(6'h09, 3'd3, 1, 32'd1, 3'd0, 1, 32'd2, 3'd0);
    step();
    dispatchValid = 0;
    checks++; if (issueValid !== 1'b1 || occupancy !== 3'd2) begin errors++; $display("FAIL ar_pre: got valid %0b occ %0d expected 1 2", issueValid, occupancy); end
    #2;
    resetN = 0;
    #1;
    checks++; if (issueValid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL ar_drop: got valid %0b occ %0d expected 0 0", issueValid, occupancy); end
    checks++; if (dispatchReady !== 1'b1 || issueOp1 !== 32'd0) begin errors++; $display("FAIL ar_outs: got dready %0b op1 %0d expected 1 0", dispatchReady, issueOp1); end
    #3;
    resetN = 1;
    step();
    checks++; if (occupancy !== 3'd0 || issueValid !== 1'b0) begin errors++; $display("FAIL ar_after: got occ %0d valid %0b expected 0 0", occupancy, issueValid); end
  endtask

  initial begin
    resetN = 0;
    idle_inputs();
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_dispatch_capture();
    test_dual_wakeup();
    test_full_and_order();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
